// File: rtl/moving_average_pow2.sv
// Streaming signed moving-average filter over a 2**LOG2_DEPTH sample window.
// Running sum is kept incrementally (add newest, subtract oldest) with a circular sample buffer.
module moving_average_pow2 #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2,
    parameter int ROUND      = 1
) (
    input  logic                                   system1000,
    input  logic                                   system1000_rst,
    input  logic                                   clear,
    input  logic                                   in_valid,
    input  logic signed [DATA_W-1:0]               in_data,
    output logic                                   out_valid,
    output logic signed [DATA_W-1:0]               out_data,
    output logic signed [DATA_W+LOG2_DEPTH-1:0]    out_sum,
    output logic                                   window_full
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;

    localparam logic signed [SUM_W:0] RND_INC =
        $signed({{SUM_W{1'b0}}, 1'b1} << (LOG2_DEPTH - 1));
    localparam logic signed [SUM_W:0] AVG_MAX =
        $signed({{(LOG2_DEPTH + 2){1'b0}}, {(DATA_W - 1){1'b1}}});
    localparam logic signed [SUM_W:0] AVG_MIN =
        $signed({{(LOG2_DEPTH + 2){1'b1}}, {(DATA_W - 1){1'b0}}});

    if (LOG2_DEPTH < 1 || LOG2_DEPTH > 8 || DATA_W < 2) begin : g_bad_params
        $error("moving_average_pow2: LOG2_DEPTH must be 1..8 and DATA_W >= 2");
    end

    // Window sum to average: optional half-LSB bias, arithmetic shift, clamp to sample range.
    function automatic logic signed [DATA_W-1:0] average(input logic signed [SUM_W-1:0] sum_v);
        logic signed [SUM_W:0] wide_v;
        logic signed [SUM_W:0] shr_v;
        wide_v = $signed({sum_v[SUM_W-1], sum_v});
        if (ROUND != 0) begin
            wide_v = wide_v + RND_INC;
        end else begin
            wide_v = wide_v;
        end
        shr_v = wide_v >>> LOG2_DEPTH;
        if (shr_v > AVG_MAX) begin
            average = AVG_MAX[DATA_W-1:0];
        end else if (shr_v < AVG_MIN) begin
            average = AVG_MIN[DATA_W-1:0];
        end else begin
            average = shr_v[DATA_W-1:0];
        end
    endfunction

    logic signed [DATA_W-1:0] buf_q [DEPTH];
    logic [LOG2_DEPTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         fill_q, fill_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [DATA_W-1:0] avg_q, avg_d;
    logic                     valid_q, valid_d;
    logic                     full_q, full_d;
    logic                     accept_s;
    logic signed [DATA_W-1:0] oldest_s;

    assign accept_s = in_valid & ~clear;
    assign oldest_s = buf_q[wr_ptr_q];

    // Next-state: the running sum register doubles as the out_sum output, so it holds when idle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        sum_d    = sum_q;
        avg_d    = avg_q;
        valid_d  = 1'b0;
        full_d   = full_q;
        if (accept_s) begin
            wr_ptr_d = wr_ptr_q + {{(LOG2_DEPTH - 1){1'b0}}, 1'b1};
            sum_d    = sum_q + {{LOG2_DEPTH{in_data[DATA_W-1]}}, in_data}
                             - {{LOG2_DEPTH{oldest_s[DATA_W-1]}}, oldest_s};
            avg_d    = average(sum_d);
            valid_d  = 1'b1;
            if (fill_q != CNT_W'(DEPTH)) begin
                fill_d = fill_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end else begin
                fill_d = fill_q;
            end
            full_d   = (fill_d == CNT_W'(DEPTH));
        end else begin
            valid_d  = 1'b0;
        end
    end

    // State registers; reset and clear both flush the whole window.
    always_ff @(posedge system1000) begin
        if (system1000_rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {LOG2_DEPTH{1'b0}};
            fill_q   <= {CNT_W{1'b0}};
            sum_q    <= {SUM_W{1'b0}};
            avg_q    <= {DATA_W{1'b0}};
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                buf_q[wr_ptr_q] <= in_data;
            end
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            sum_q    <= sum_d;
            avg_q    <= avg_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = avg_q;
    assign out_sum     = sum_q;
    assign window_full = full_q;

endmodule

// File: tb/tb_moving_average_pow2.sv
// Directed bench for moving_average_pow2 (DATA_W=8, LOG2_DEPTH=2), with a ROUND=1 and a ROUND=0 instance.
module tb_moving_average_pow2;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              ov1, ov0;
    logic signed [7:0] od1, od0;
    logic signed [9:0] os1, os0;
    logic              wf1, wf0;

    int errors = 0;
    int checks = 0;

    moving_average_pow2 #(.DATA_W(8), .LOG2_DEPTH(2), .ROUND(1)) u_dut (
        .system1000(clk), .system1000_rst(rst), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .out_valid(ov1), .out_data(od1), .out_sum(os1), .window_full(wf1)
    );

    moving_average_pow2 #(.DATA_W(8), .LOG2_DEPTH(2), .ROUND(0)) u_dut_r0 (
        .system1000(clk), .system1000_rst(rst), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .out_valid(ov0), .out_data(od0), .out_sum(os0), .window_full(wf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock: drive inputs on the falling edge, sample outputs 1 time unit after the rising edge.
    task automatic step(input logic r, input logic c, input logic v, input logic signed [7:0] d);
        @(negedge clk);
        rst = r; clear = c; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input string tag, input logic v, input int s, input int a, input logic w);
        chk({tag, ".valid"}, 32'(v), 32'(ov1) & 32'd1);
        chk({tag, ".sum"}, os1, s);
        chk({tag, ".data"}, od1, a);
        chk({tag, ".full"}, 32'(wf1) & 32'd1, 32'(w) & 32'd1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'sd0;
        step(1'b1, 1'b1, 1'b1, 8'sd55);
        expect1("reset", 1'b0, 0, 0, 1'b0);
        chk("reset.r0_sum", os0, 0);

        // Ramp 4,8,12,16,20
        step(1'b0, 1'b0, 1'b1, 8'sd4);  expect1("ramp0", 1'b1, 4, 1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd8);  expect1("ramp1", 1'b1, 12, 3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd12); expect1("ramp2", 1'b1, 24, 6, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd16); expect1("ramp3", 1'b1, 40, 10, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'sd20); expect1("ramp4", 1'b1, 56, 14, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'sd0);  expect1("ramp_idle", 1'b0, 56, 14, 1'b1);

        // Reset mid-stream, then refill with the ramp
        step(1'b1, 1'b0, 1'b1, 8'sd99); expect1("rst_mid", 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd4);  expect1("refill0", 1'b1, 4, 1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd8);  expect1("refill1", 1'b1, 12, 3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd12); expect1("refill2", 1'b1, 24, 6, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd16); expect1("refill3", 1'b1, 40, 10, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'sd20); expect1("refill4", 1'b1, 56, 14, 1'b1);

        // Clear with in_valid mid-stream: sample dropped, then 8 -> sum 8, avg 2
        step(1'b0, 1'b1, 1'b1, 8'sd100); expect1("clear", 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd8);   expect1("post_clear", 1'b1, 8, 2, 1'b0);

        // Extremes: four -128, then four 127
        step(1'b0, 1'b1, 1'b0, 8'sd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, -8'sd128);
        expect1("neg_full", 1'b1, -512, -128, 1'b1);
        chk("neg_full.r0_data", od0, -128);
        step(1'b0, 1'b0, 1'b1, 8'sd127); expect1("pos0", 1'b1, -257, -64, 1'b1);
        chk("pos0.r0_data", od0, -65);
        step(1'b0, 1'b0, 1'b1, 8'sd127); expect1("pos1", 1'b1, -2, 0, 1'b1);
        chk("pos1.r0_data", od0, -1);
        step(1'b0, 1'b0, 1'b1, 8'sd127); expect1("pos2", 1'b1, 253, 63, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'sd127); expect1("pos3", 1'b1, 508, 127, 1'b1);
        chk("pos3.r0_data", od0, 127);
        chk("pos3.r0_sum", os0, 508);

        // Rounding: window {-2,0,0,0} then {-3,0,0,0}
        step(1'b0, 1'b1, 1'b0, 8'sd0);
        step(1'b0, 1'b0, 1'b1, -8'sd2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'sd0);
        expect1("rnd_m2", 1'b1, -2, 0, 1'b1);
        chk("rnd_m2.r0_data", od0, -1);
        step(1'b0, 1'b0, 1'b1, -8'sd3);
        expect1("rnd_m3", 1'b1, -3, -1, 1'b1);
        chk("rnd_m3.r0_data", od0, -1);

        // Valid gaps: 10,_,_,20,_,30,40
        step(1'b0, 1'b1, 1'b0, 8'sd0);
        step(1'b0, 1'b0, 1'b1, 8'sd10); expect1("gap_a", 1'b1, 10, 3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'sd77); expect1("gap_h1", 1'b0, 10, 3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'sd0);  expect1("gap_h2", 1'b0, 10, 3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd20); expect1("gap_b", 1'b1, 30, 8, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'sd0);  expect1("gap_h3", 1'b0, 30, 8, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd30); expect1("gap_c", 1'b1, 60, 15, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'sd40); expect1("gap_d", 1'b1, 100, 25, 1'b1);
        chk("gap_d.r0_data", od0, 25);
        chk("gap_d.r0_valid", 32'(ov0) & 32'd1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
